pool_window_scheduler: RTL

- Sequences one max-pooling pass over a single feature-map channel held in a single-port, 1-cycle-latency read memory.
- Gathers each non-overlapping KxK window by issuing reads, then hands the window to the team's max-pooling datapath.
- Waits for the datapath's completion, then writes the pooled value to the output-map memory.
- Sits between the feature-map buffer, the pooling unit and the output buffer in the CNN layer pipeline.

---
 rtl/pool_window_scheduler_pkg.sv | 14 +
 rtl/pool_window_scheduler_if.sv | 31 +++
 rtl/pool_window_scheduler_addr_gen.sv | 62 ++++++
 rtl/pool_window_scheduler.sv | 94 +++++++++
 4 files changed

// File: rtl/pool_window_scheduler_pkg.sv
// Shared types for the pooling window scheduler: sample format and controller states.
package pool_pkg;
  localparam int IL = 8;
  localparam int FL = 12;
  localparam int DW = IL + FL;

  typedef logic [DW-1:0] sample_t;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, POOL, WRITE} state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/pool_window_scheduler_if.sv
// Scheduler bus: start/status, feature-map read port, pooling-unit link, output write port.
interface pool_window_scheduler_if import pool_pkg::*; #(
  parameter int K   = 2,
  parameter int AW  = 6,
  parameter int OAW = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  sample_t               rd_data;
  sample_t [K*K-1:0]     win;
  logic                  pool_en;
  logic                  pool_load;
  logic                  pool_done;
  sample_t               pool_result;
  logic                  wr_en;
  logic [OAW-1:0]        wr_addr;
  sample_t               wr_data;

  modport slave (
    input  start, rd_data, pool_done, pool_result,
    output busy, done, rd_en, rd_addr, win, pool_en, pool_load, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, rd_data, pool_done, pool_result,
    input  busy, done, rd_en, rd_addr, win, pool_en, pool_load, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_window_scheduler_addr_gen.sv
// Window/sample counters and the derived feature-map read and output write addresses.
module pool_addr_gen import pool_pkg::*; #(
  parameter int K   = 2,
  parameter int H   = 8,
  parameter int W   = 8,
  parameter int AW  = 6,
  parameter int OAW = 4,
  parameter int NW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_adv_n,
  input  logic           i_adv_win,
  output logic [AW-1:0]  o_rd_addr,
  output logic [OAW-1:0] o_wr_addr,
  output logic [NW-1:0]  o_n,
  output logic           o_last_in_win,
  output logic           o_last_win
);
  localparam int OXN = W / K;
  localparam int OYN = H / K;
  localparam int XW  = clog2_min1(OXN);
  localparam int YW  = clog2_min1(OYN);

  logic [NW-1:0] r_n;
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic          w_last_x, w_last_y;

  assign w_last_x      = (r_ox == XW'(OXN - 1));
  assign w_last_y      = (r_oy == YW'(OYN - 1));
  assign o_last_in_win = (r_n == NW'(K*K - 1));
  assign o_last_win    = w_last_x && w_last_y;
  assign o_n           = r_n;

  assign o_rd_addr = AW'((int'(r_oy)*K + int'(r_n)/K)*W + int'(r_ox)*K + int'(r_n)%K);
  assign o_wr_addr = OAW'(int'(r_oy)*OXN + int'(r_ox));

  // Advancing past the last window wraps everything to 0, so IDLE shows address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n  <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_clear) begin
      r_n  <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_adv_win) begin
      r_n <= '0;
      if (w_last_x) begin
        r_ox <= '0;
        r_oy <= w_last_y ? '0 : r_oy + 1'b1;
      end else begin
        r_ox <= r_ox + 1'b1;
      end
    end else if (i_adv_n) begin
      r_n <= r_n + 1'b1;
    end
  end
endmodule

// File: rtl/pool_window_scheduler.sv
// Max-pool pass sequencer: gathers each KxK window, hands it to the pooling unit, writes the result.
module pool_window_scheduler import pool_pkg::*; #(
  parameter int K   = 2,
  parameter int H   = 8,
  parameter int W   = 8,
  parameter int AW  = $clog2(H*W),
  parameter int OAW = clog2_min1((H/K)*(W/K))
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pool_window_scheduler_if.slave bus
);
  localparam int NW = clog2_min1(K*K);

  state_e            r_state, w_next;
  logic              w_clear, w_adv_n, w_adv_win, w_last_in_win, w_last_win;
  logic [NW-1:0]     w_n, r_cap_idx;
  logic [AW-1:0]     w_rd_addr;
  logic [OAW-1:0]    w_wr_addr;
  logic              r_cap_vld, r_load, r_done;
  sample_t [K*K-1:0] r_win;
  sample_t           r_wr_data;

  pool_addr_gen #(.K(K), .H(H), .W(W), .AW(AW), .OAW(OAW), .NW(NW)) u_addr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_adv_n      (w_adv_n),
    .i_adv_win    (w_adv_win),
    .o_rd_addr    (w_rd_addr),
    .o_wr_addr    (w_wr_addr),
    .o_n          (w_n),
    .o_last_in_win(w_last_in_win),
    .o_last_win   (w_last_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // r_done marks the done cycle, during which start is still ignored.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_adv_n   = 1'b0;
    w_adv_win = 1'b0;
    case (r_state)
      IDLE:  if (bus.start && !r_done) begin
               w_clear = 1'b1;
               w_next  = FETCH;
             end
      FETCH: if (w_last_in_win) w_next = DRAIN;
             else               w_adv_n = 1'b1;
      DRAIN: w_next = POOL;
      POOL:  if (bus.pool_done) w_next = WRITE;
      WRITE: begin
               w_adv_win = 1'b1;
               w_next    = w_last_win ? IDLE : FETCH;
             end
      default: w_next = IDLE;
    endcase
  end

  // Read data lands one cycle after its strobe; the slot index travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_win     <= '0;
      r_load    <= 1'b0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_cap_vld <= (r_state == FETCH);
      r_cap_idx <= w_n;
      if (r_cap_vld) r_win[r_cap_idx] <= bus.rd_data;
      r_load    <= (r_state == DRAIN);
      if (r_state == POOL && bus.pool_done) r_wr_data <= bus.pool_result;
      r_done    <= (r_state == WRITE) && w_last_win;
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.rd_en     = (r_state == FETCH);
  assign bus.rd_addr   = w_rd_addr;
  assign bus.win       = r_win;
  assign bus.pool_en   = (r_state == POOL);
  assign bus.pool_load = (r_state == POOL) && r_load;
  assign bus.wr_en     = (r_state == WRITE);
  assign bus.wr_addr   = w_wr_addr;
  assign bus.wr_data   = r_wr_data;
endmodule
